// File: rtl/msi_irq_scheduler.sv
// Round-robin MSI scheduler: edge-latched pending bits with per-source masking,
// vector folding into the host-allocated MSI count, and an enforced inter-message gap.
module msi_irq_scheduler #(
  parameter int unsigned N_IRQ      = 8,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             msi_enable,
  input  logic [2:0]       msi_mme,
  output logic             app_msi_req,
  output logic [4:0]       app_msi_num,
  output logic [2:0]       app_msi_tc,
  input  logic             app_msi_ack,
  output logic [N_IRQ-1:0] pending
);

  localparam int unsigned IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } state_t;

  state_t           state_q;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] pending_d;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] eligible;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    g_q;
  logic [7:0]       gap_q;
  logic             req_q;
  logic [4:0]       num_q;

  logic             sel_valid;
  logic [IW-1:0]    sel_idx;
  logic [4:0]       sel_num;
  logic [2:0]       mme_eff;
  logic [5:0]       vec_cnt;

  assign rise     = irq & ~irq_q;
  assign eligible = pending_q & ~irq_mask & {N_IRQ{msi_enable}};

  always_comb begin
    clr = '0;
    if (state_q == S_REQ && app_msi_ack) begin
      clr[g_q] = 1'b1;
    end
  end

  // A rise on the bit being cleared wins, so the source is delivered again.
  assign pending_d = (pending_q & ~clr) | rise;

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 1; i <= N_IRQ; i++) begin
      if (!sel_valid && eligible[IW'((32'(last_q) + i) % N_IRQ)]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'((32'(last_q) + i) % N_IRQ);
      end
    end
  end

  // Sources beyond the allocated vector count share the top vector.
  always_comb begin
    mme_eff = (msi_mme > 3'd5) ? 3'd5 : msi_mme;
    vec_cnt = 6'd1 << mme_eff;
    if (6'(sel_idx) < vec_cnt) begin
      sel_num = 5'(sel_idx);
    end else begin
      sel_num = 5'(vec_cnt - 6'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      last_q    <= IW'(N_IRQ - 1);
      g_q       <= '0;
      gap_q     <= '0;
      req_q     <= 1'b0;
      num_q     <= '0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          if (sel_valid) begin
            g_q     <= sel_idx;
            num_q   <= sel_num;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (app_msi_ack) begin
            req_q  <= 1'b0;
            last_q <= g_q;
            if (GAP_CYCLES == 0) begin
              state_q <= S_IDLE;
            end else begin
              gap_q   <= 8'(GAP_CYCLES);
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          gap_q <= gap_q - 8'd1;
          if (gap_q <= 8'd1) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign app_msi_req = req_q;
  assign app_msi_num = num_q;
  assign app_msi_tc  = 3'b000;
  assign pending     = pending_q;

endmodule

// File: tb/tb_msi_irq_scheduler.sv
// Directed bench for msi_irq_scheduler: a cycle-level behavioural model checked every cycle,
// plus literal expectations on grant order, vector numbers and timing.
module tb_msi_irq_scheduler;

  localparam int N   = 8;
  localparam int GAP = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq = '0;
  logic [N-1:0] irq_mask = '0;
  logic         msi_enable = 1'b1;
  logic [2:0]   msi_mme = 3'd3;
  logic         app_msi_ack = 1'b0;
  logic         app_msi_req;
  logic [4:0]   app_msi_num;
  logic [2:0]   app_msi_tc;
  logic [N-1:0] pending;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  msi_irq_scheduler #(.N_IRQ(N), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .irq(irq), .irq_mask(irq_mask),
    .msi_enable(msi_enable), .msi_mme(msi_mme),
    .app_msi_req(app_msi_req), .app_msi_num(app_msi_num), .app_msi_tc(app_msi_tc),
    .app_msi_ack(app_msi_ack), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: pending set, an outstanding-message flag and the earliest
  // edge at which the next message may start.
  logic [N-1:0] m_prev, m_pend, m_rise, m_clr;
  logic         m_busy, m_req, m_live = 1'b0;
  logic [4:0]   m_num;
  int           m_last, m_g, m_next_ok;

  function automatic logic [4:0] vec_of(input int src, input logic [2:0] mme);
    int a;
    a = 1 << ((mme > 3'd5) ? 5 : int'(mme));
    return (src < a) ? 5'(src) : 5'(a - 1);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_prev = '0; m_pend = '0; m_busy = 1'b0; m_req = 1'b0; m_num = '0;
      m_last = N - 1; m_g = 0; m_next_ok = 0; m_live = 1'b1;
    end else begin
      m_rise = irq & ~m_prev;
      m_prev = irq;
      m_clr  = '0;
      if (m_busy) begin
        if (app_msi_ack) begin
          m_clr[m_g] = 1'b1;
          m_busy = 1'b0; m_req = 1'b0;
          m_last = m_g;
          m_next_ok = cyc + GAP + 1;
        end
      end else if (cyc >= m_next_ok && msi_enable) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (!m_busy && m_pend[idx] && !irq_mask[idx]) begin
            m_busy = 1'b1; m_req = 1'b1; m_g = idx;
            m_num = vec_of(idx, msi_mme);
          end
        end
      end
      m_pend = (m_pend & ~m_clr) | m_rise;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_req", 32'(app_msi_req), 32'(m_req));
      check("cyc_num", 32'(app_msi_num), 32'(m_num));
      check("cyc_pending", 32'(pending), 32'(m_pend));
      check("cyc_tc", 32'(app_msi_tc), 32'd0);
    end
  end

  // Grant log: vector number and edge index of every request rising edge.
  int   log_num[$];
  int   log_cyc[$];
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (app_msi_req === 1'b1 && !prev_req) begin
      log_num.push_back(int'(app_msi_num));
      log_cyc.push_back(cyc);
    end
    prev_req = (app_msi_req === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; irq = '0; irq_mask = '0; msi_enable = 1'b1; msi_mme = 3'd3; app_msi_ack = 1'b0;
    tick(3);
    reset = 1'b0;
  endtask

  task automatic wait_req(input string name, output int n);
    n = 0;
    while (app_msi_req !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    check(name, 32'(app_msi_req), 32'd1);
  endtask

  task automatic ack_pulse();
    app_msi_ack = 1'b1;
    tick(1);
    app_msi_ack = 1'b0;
  endtask

  initial begin
    int n, b;

    // 1: single source, reset state, latency and clear on ack
    do_reset();
    check("rst_req", 32'(app_msi_req), 32'd0);
    check("rst_num", 32'(app_msi_num), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    irq = 8'h08;
    tick(1);
    check("t1_pend_set", 32'(pending), 32'h08);
    check("t1_no_req_yet", 32'(app_msi_req), 32'd0);
    tick(1);
    check("t1_req", 32'(app_msi_req), 32'd1);
    check("t1_num", 32'(app_msi_num), 32'd3);
    tick(2);
    check("t1_req_held", 32'(app_msi_req), 32'd1);
    ack_pulse();
    check("t1_req_fall", 32'(app_msi_req), 32'd0);
    check("t1_pend_clr", 32'(pending), 32'd0);
    irq = '0;
    tick(8);

    // 2: round-robin over 0,2,5 with immediate ack
    do_reset();
    b = log_num.size();
    irq = 8'h25;
    for (int i = 0; i < 3; i++) begin
      wait_req("t2_req", n);
      ack_pulse();
    end
    irq = '0;
    tick(8);
    check("t2_count", 32'(log_num.size() - b), 32'd3);
    if (log_num.size() - b == 3) begin
      check("t2_num0", 32'(log_num[b]), 32'd0);
      check("t2_num1", 32'(log_num[b+1]), 32'd2);
      check("t2_num2", 32'(log_num[b+2]), 32'd5);
      check("t2_space01", 32'(log_cyc[b+1] - log_cyc[b] >= 6), 32'd1);
      check("t2_space12", 32'(log_cyc[b+2] - log_cyc[b+1] >= 6), 32'd1);
    end

    // 3: mask and msi_enable gating
    do_reset();
    irq_mask = 8'h02; irq = 8'h02;
    tick(3);
    check("t3_masked_pend", 32'(pending), 32'h02);
    check("t3_masked_noreq", 32'(app_msi_req), 32'd0);
    irq_mask = '0;
    tick(1);
    check("t3_unmask_req", 32'(app_msi_req), 32'd1);
    check("t3_unmask_num", 32'(app_msi_num), 32'd1);
    ack_pulse();
    irq = '0;
    tick(6);
    msi_enable = 1'b0; irq = 8'h02;
    tick(3);
    check("t3_dis_pend", 32'(pending), 32'h02);
    check("t3_dis_noreq", 32'(app_msi_req), 32'd0);
    msi_enable = 1'b1;
    tick(1);
    check("t3_en_req", 32'(app_msi_req), 32'd1);
    msi_enable = 1'b0;
    tick(2);
    check("t3_req_hold_dis", 32'(app_msi_req), 32'd1);
    ack_pulse();
    check("t3_ack_dis", 32'(app_msi_req), 32'd0);
    msi_enable = 1'b1; irq = '0;
    tick(6);

    // 4: vector folding for different msi_mme values
    do_reset();
    b = log_num.size();
    msi_mme = 3'd1; irq = 8'h42;
    for (int i = 0; i < 2; i++) begin
      wait_req("t4_req_mme1", n);
      ack_pulse();
    end
    irq = '0;
    tick(8);
    msi_mme = 3'd0; irq = 8'h42;
    for (int i = 0; i < 2; i++) begin
      wait_req("t4_req_mme0", n);
      ack_pulse();
    end
    irq = '0;
    tick(8);
    msi_mme = 3'd7; irq = 8'h40;
    wait_req("t4_req_mme7", n);
    ack_pulse();
    irq = '0;
    tick(8);
    check("t4_count", 32'(log_num.size() - b), 32'd5);
    if (log_num.size() - b == 5) begin
      check("t4_mme1_src1", 32'(log_num[b]), 32'd1);
      check("t4_mme1_src6", 32'(log_num[b+1]), 32'd1);
      check("t4_mme0_a", 32'(log_num[b+2]), 32'd0);
      check("t4_mme0_b", 32'(log_num[b+3]), 32'd0);
      check("t4_mme7_src6", 32'(log_num[b+4]), 32'd6);
    end

    // 5: new rise of the granted source on its own ack edge
    do_reset();
    irq = 8'h10;
    tick(2);
    check("t5_req", 32'(app_msi_req), 32'd1);
    irq = '0;
    tick(1);
    irq = 8'h10; app_msi_ack = 1'b1;
    tick(1);
    app_msi_ack = 1'b0;
    check("t5_ack_fall", 32'(app_msi_req), 32'd0);
    check("t5_pend_kept", 32'(pending), 32'h10);
    wait_req("t5_req2", n);
    check("t5_gap_cycles", 32'(n), 32'd5);
    check("t5_num2", 32'(app_msi_num), 32'd4);
    ack_pulse();
    irq = '0;
    tick(8);

    // 6: reset during a request, ack during reset, held irq after reset
    do_reset();
    irq = 8'h0A;
    tick(1);
    irq = 8'h08;
    tick(1);
    check("t6_req", 32'(app_msi_req), 32'd1);
    check("t6_pend", 32'(pending), 32'h0A);
    reset = 1'b1; app_msi_ack = 1'b1;
    tick(1);
    check("t6_rst_req", 32'(app_msi_req), 32'd0);
    check("t6_rst_num", 32'(app_msi_num), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'd0);
    tick(2);
    b = log_num.size();
    reset = 1'b0; app_msi_ack = 1'b0;
    for (int i = 0; i < 30; i++) begin
      app_msi_ack = (app_msi_req === 1'b1);
      tick(1);
    end
    app_msi_ack = 1'b0;
    check("t6_one_msg", 32'(log_num.size() - b), 32'd1);
    if (log_num.size() - b == 1) check("t6_num", 32'(log_num[b]), 32'd3);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/msi_irq_scheduler.md
Name: msi_irq_scheduler

Overview:
Arbitrates N_IRQ internal interrupt sources onto the single MSI request interface of the PCIe hard IP (app_msi_req/app_msi_num/app_msi_ack). It sits between the fabric interrupt lines and pcie_msi_intr-style consumers, and replaces fixed-priority encoding. Per source, it latches rising edges into a pending bit and honours a per-source mask. It selects the next message round-robin, maps the source to a vector within the host-allocated MSI count, and enforces a minimum gap between messages.

Parameters:
N_IRQ, 8, number of interrupt sources; legal 1..32.
GAP_CYCLES, 4, idle cycles forced after each acked message; legal 0..255.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
irq  in  N_IRQ  interrupt sources, rising-edge sensitive, synchronous to clk
irq_mask  in  N_IRQ  1 = source masked (it still pends but is not delivered)
msi_enable  in  1  MSI enable from config space; 0 blocks new requests
msi_mme  in  3  multiple-message-enable; allocated vectors = 2^min(msi_mme,5)
app_msi_req  out  1  MSI request to hard IP
app_msi_num  out  5  MSI vector number
app_msi_tc  out  3  traffic class, constant 0
app_msi_ack  in  1  single-cycle acknowledge from hard IP
pending  out  N_IRQ  current pending bits (status)

Behaviour:
- Reset (synchronous): app_msi_req=0, app_msi_num=0, app_msi_tc=0, pending=0, irq_q=0, rr pointer last=N_IRQ-1, gap counter=0, state=IDLE.
- Edge detect: irq_q <= irq every cycle. rise = irq & ~irq_q. Because irq_q resets to 0, a source held high through reset pends once after reset.
- Pending update each cycle: pending <= (pending & ~clr) | rise. clr is one-hot for the granted source in the cycle app_msi_ack is sampled during REQ. If set and clear coincide on the same bit, set wins: the bit stays 1 and the source is delivered again.
- eligible = pending & ~irq_mask, qualified by msi_enable.
- FSM IDLE:
  - If eligible is nonzero, pick the first set bit scanning from last+1 upward and wrapping at N_IRQ. Register grant index g, drive app_msi_num=map(g), set app_msi_req=1, go to REQ.
  - The request is visible on the edge after pending sets. That is two edges after irq is first sampled high.
- FSM REQ:
  - app_msi_req and app_msi_num are held stable until app_msi_ack=1.
  - Masking the source or deasserting msi_enable mid-request does not withdraw the request. The handshake always completes.
  - On ack: app_msi_req<=0, clear pending[g], last<=g. If GAP_CYCLES=0, go to IDLE; otherwise load the counter with GAP_CYCLES and go to GAP.
  - An ack seen in IDLE or GAP is ignored.
- FSM GAP: decrement the counter each cycle and go to IDLE when it reaches 1. The next request is therefore asserted no earlier than GAP_CYCLES+1 cycles after the ack edge.
- Vector map: A = 1 << min(msi_mme,5). map(g) = g if g < A, else A-1 (sources share the top vector). msi_mme is sampled at grant time only.
- Round-robin: a source just served has lowest priority on the next arbitration. With every source continuously pending, the grants visit indices 0,1,...,N_IRQ-1,0,...
- Throughput: at most one message per 2+GAP_CYCLES cycles, given ack one cycle after req.
- No output is driven combinationally from an input.

Test Plan:
1. Single source: N_IRQ=8, GAP=4, mme=3, msi_enable=1. Pulse irq[3] 0→1, ack 3 cycles after req. Required: req rises 2 edges after irq sampled high, app_msi_num=3, req falls on the ack edge, pending[3] clears, pending=0 afterwards.
2. Round-robin: raise irq[0], irq[2], irq[5] in the same cycle, with immediate ack. Required: num sequence 0,2,5, successive req rising edges ≥6 cycles apart (GAP=4), and never two requests outstanding.
3. Mask/enable: irq[1] rises while irq_mask[1]=1. Required: pending[1]=1, no req. Clear the mask; req with num=1 follows one cycle later. Repeat with msi_enable=0: no req until it rises. Deassert msi_enable during REQ: req stays high until ack.
4. Vector sharing: mme=1 (2 vectors), irq[6] and irq[1] pending. Required: the grant for source 1 gives num=1 and the grant for source 6 gives num=1. Then mme=0 gives num=0 for every source; mme=7 behaves as 32 vectors, so source 6 gives num=6.
5. Re-edge during ack: irq[4] toggles low then high so that a new rise lands exactly on the ack cycle of its own request. Required: pending[4] remains 1 and a second message with num=4 is sent after the gap.
6. Reset mid-request: assert reset while req=1 and pending=8'h0A. Required: the next cycle shows req=0, num=0, pending=0, and an ack arriving during reset is ignored. After reset, irq held high since before reset produces exactly one message.
